// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the ADC-side deserialiser and the DAC-side serialiser.
package i2s_pkg;

    localparam int unsigned I2S_DATA_WIDTH = 16;

    typedef logic signed [I2S_DATA_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } rx_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_serial_to_parallel_if.sv
// Codec-pin / parallel-sample bundle for the I2S receive path.
// Optional macro I2S_RX_MONO_MIX_EN adds the mono_sample signal.
interface i2s_serial_to_parallel_if
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH
);

    logic                  lrclk;
    logic                  adc_data;
    logic [DATA_WIDTH-1:0] left_sample;
    logic [DATA_WIDTH-1:0] right_sample;
    logic                  sample_valid;
    logic                  frame_error;
`ifdef I2S_RX_MONO_MIX_EN
    logic [DATA_WIDTH-1:0] mono_sample;

    // Receiver side: takes the codec pins, drives the parallel words.
    modport master (
        input  lrclk, adc_data,
        output left_sample, right_sample, sample_valid, frame_error, mono_sample
    );

    // Pin-driver / consumer side.
    modport slave (
        output lrclk, adc_data,
        input  left_sample, right_sample, sample_valid, frame_error, mono_sample
    );
`else
    // Receiver side: takes the codec pins, drives the parallel words.
    modport master (
        input  lrclk, adc_data,
        output left_sample, right_sample, sample_valid, frame_error
    );

    // Pin-driver / consumer side.
    modport slave (
        output lrclk, adc_data,
        input  left_sample, right_sample, sample_valid, frame_error
    );
`endif

endinterface

// File: rtl/i2s_serial_to_parallel.sv
// I2S receiver: MSB-first serial ADC data to parallel left/right words, bclk domain.
// Optional macro I2S_RX_MONO_MIX_EN adds a registered (L+R)>>>1 mono output.
module i2s_serial_to_parallel
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH
)
(
    input logic                      bclk,
    input logic                      reset_n,
    i2s_serial_to_parallel_if.master bus
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    rx_state_t             state_q, state_d;
    logic                  lrclk_d1_q;
    logic                  chan_q, chan_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic                  lr_edge;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] word;
    logic                  restart;

`ifdef I2S_RX_MONO_MIX_EN
    logic [DATA_WIDTH-1:0] mono_q, mono_d;
    logic [DATA_WIDTH:0]   mix_sum;
`endif

    assign lr_edge = bus.lrclk ^ lrclk_d1_q;
    assign shifted = {shift_q[DATA_WIDTH-2:0], bus.adc_data};

    // Next-state, word assembly and completion strobes.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        word_done = 1'b0;
        word      = '0;
        restart   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (lr_edge) begin
                    restart = 1'b1;
                end
            end
            SHIFT: begin
                if (!lr_edge) begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q - CNT_ONE;
                    if (bit_cnt_q == CNT_ONE) begin
                        word_done = 1'b1;
                        word      = shifted;
                        state_d   = WAIT;
                    end
                end else begin
                    // A slot of exactly DATA_WIDTH bclks delivers its LSB on the
                    // edge cycle; anything shorter is left-justified and flagged.
                    word_done = 1'b1;
                    restart   = 1'b1;
                    if (bit_cnt_q == CNT_ONE) begin
                        word = shifted;
                    end else begin
                        word  = shift_q << bit_cnt_q;
                        err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (lr_edge) begin
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (restart) begin
            state_d   = SHIFT;
            chan_d    = bus.lrclk;
            bit_cnt_d = CNT_FULL;
            shift_d   = '0;
        end

        if (word_done) begin
            if (chan_q == CH_RIGHT) begin
                right_d = word;
                valid_d = 1'b1;
            end else begin
                left_d = word;
            end
        end
    end

`ifdef I2S_RX_MONO_MIX_EN
    // Mono mix of the held left word and the right word completing this cycle.
    always_comb begin
        mix_sum = {left_q[DATA_WIDTH-1], left_q} + {word[DATA_WIDTH-1], word};
        mono_d  = mono_q;
        if (word_done && (chan_q == CH_RIGHT)) begin
            mono_d = mix_sum[DATA_WIDTH:1];
        end
    end

    // Mono output register.
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            mono_q <= '0;
        end else begin
            mono_q <= mono_d;
        end
    end

    assign bus.mono_sample = mono_q;
`endif

    // State, datapath and output registers.
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lrclk_d1_q <= 1'b0;
            chan_q     <= CH_LEFT;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lrclk_d1_q <= bus.lrclk;
            chan_q     <= chan_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            left_q     <= left_d;
            right_q    <= right_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.left_sample  = left_q;
    assign bus.right_sample = right_q;
    assign bus.sample_valid = valid_q;
    assign bus.frame_error  = err_q;

endmodule

// File: tb/tb_i2s_serial_to_parallel.sv
// Self-checking bench for i2s_serial_to_parallel; slot-level reference model.
// Define I2S_RX_MONO_MIX_EN to also check mono_sample.
module tb_i2s_serial_to_parallel;

    localparam int DW   = 16;
    localparam int MAXT = 2048;

    logic bclk    = 1'b0;
    logic reset_n = 1'b0;

    i2s_serial_to_parallel_if #(.DATA_WIDTH(DW)) bus ();

    i2s_serial_to_parallel #(.DATA_WIDTH(DW)) dut (
        .bclk    (bclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 bclk = ~bclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Slot list for the next segment: length in bclks and word transmitted.
    int          slot_len[$];
    logic [DW-1:0] slot_word[$];

    // Per-bclk stimulus and expected completion events.
    logic          lr_s[MAXT];
    logic          ad_s[MAXT];
    int            ev_kind[MAXT];   // 0 none, 1 left word, 2 right word
    logic [DW-1:0] ev_word[MAXT];
    logic          ev_err[MAXT];

    logic [DW-1:0] m_left, m_right, m_mono;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_slot(input int len, input logic [DW-1:0] w);
        slot_len.push_back(len);
        slot_word.push_back(w);
    endtask

`ifdef I2S_RX_MONO_MIX_EN
    function automatic logic [DW-1:0] mono_ref(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int sl, sr, s;
        sl = $signed(l);
        sr = $signed(r);
        s  = sl + sr;
        // floor((l+r)/2)
        if (s < 0 && (s % 2) != 0) s = s / 2 - 1;
        else s = s / 2;
        return DW'(s);
    endfunction
`endif

    task automatic check_outputs_zero(input string tag);
        check({tag, "_left"},  bus.left_sample,  '0);
        check({tag, "_right"}, bus.right_sample, '0);
        check({tag, "_valid"}, DW'(bus.sample_valid), '0);
        check({tag, "_err"},   DW'(bus.frame_error),  '0);
`ifdef I2S_RX_MONO_MIX_EN
        check({tag, "_mono"},  bus.mono_sample,  '0);
`endif
    endtask

    // Builds the bclk stream from the slot list, applies reset, plays it and
    // checks every cycle. abort_at >= 0 stops early (mid-word) without cleanup.
    task automatic play(input string tag, input int abort_at);
        int total, t0, n, c, cap, tc;
        logic lr;
        logic [DW-1:0] w;
        logic exp_valid;

        // Trailing slot long enough to complete the last listed slot.
        add_slot(DW + 4, DW'($urandom));
        total = 2;
        foreach (slot_len[s]) total += slot_len[s];
        if (total > MAXT) begin
            $display("FAIL %s_build: stream length %0d exceeds %0d", tag, total, MAXT);
            $fatal(1, "stream too long");
        end

        for (int t = 0; t < total; t++) begin
            lr_s[t]    = 1'b0;
            ad_s[t]    = 1'($urandom_range(0, 1));
            ev_kind[t] = 0;
            ev_word[t] = '0;
            ev_err[t]  = 1'b0;
        end

        t0 = 0;
        lr = 1'b0;
        foreach (slot_len[s]) begin
            n  = slot_len[s];
            w  = slot_word[s];
            lr = 1'(s % 2);
            for (int p = 0; p < n; p++) lr_s[t0 + p] = lr;
            // MSB one bclk after the lrclk change; at most DW bits go out.
            c = (n < DW) ? n : DW;
            for (int p = 1; p <= c; p++) ad_s[t0 + p] = w[DW - p];
            // Slot 0 starts without an lrclk edge and is never reported.
            if (s > 0) begin
                cap = (n < DW) ? n - 1 : DW;
                tc  = t0 + c;
                ev_kind[tc] = lr ? 2 : 1;
                ev_word[tc] = (w >> (DW - cap)) << (DW - cap);
                ev_err[tc]  = (n < DW);
            end
            t0 += n;
        end
        for (int t = t0; t < total; t++) lr_s[t] = lr;

        // Asynchronous reset, applied away from the clock edge.
        @(posedge bclk);
        #2;
        reset_n      = 1'b0;
        bus.lrclk    = 1'b0;
        bus.adc_data = 1'b0;
        #1;
        check_outputs_zero({tag, "_rst"});
        m_left  = '0;
        m_right = '0;
        m_mono  = '0;
        repeat (3) @(negedge bclk);

        for (int t = 0; t < total; t++) begin
            if (abort_at >= 0 && t >= abort_at) break;
            if (t > 0) @(negedge bclk);
            else reset_n = 1'b1;
            bus.lrclk    = lr_s[t];
            bus.adc_data = ad_s[t];
            @(posedge bclk);
            #1;
            exp_valid = 1'b0;
            if (ev_kind[t] == 1) m_left = ev_word[t];
            if (ev_kind[t] == 2) begin
                m_right   = ev_word[t];
                exp_valid = 1'b1;
`ifdef I2S_RX_MONO_MIX_EN
                m_mono    = mono_ref(m_left, m_right);
`endif
            end
            check({tag, "_left"},  bus.left_sample,  m_left);
            check({tag, "_right"}, bus.right_sample, m_right);
            check({tag, "_valid"}, DW'(bus.sample_valid), DW'(exp_valid));
            check({tag, "_err"},   DW'(bus.frame_error),  DW'(ev_err[t]));
`ifdef I2S_RX_MONO_MIX_EN
            check({tag, "_mono"},  bus.mono_sample, m_mono);
`endif
        end

        slot_len.delete();
        slot_word.delete();
    endtask

    initial begin
        bus.lrclk    = 1'b0;
        bus.adc_data = 1'b0;

        // 64-bclk frames.
        for (int f = 0; f < 3; f++) begin
            add_slot(32, 16'hA5C3);
            add_slot(32, 16'h1234);
        end
        play("f64", -1);

        // 16-bclk slots: LSB arrives on the edge cycle.
        for (int f = 0; f < 4; f++) begin
            add_slot(16, 16'h8001);
            add_slot(16, 16'h7FFE);
        end
        play("f32", -1);

        // Short right slot of 10 bclks (9 bits delivered).
        add_slot(32, 16'h1111);
        add_slot(32, 16'h2222);
        add_slot(32, 16'h3C3C);
        add_slot(10, 16'hB5FF);
        add_slot(32, 16'h4444);
        add_slot(32, 16'h5555);
        play("short", -1);

        // 48-bclk slots with trailing garbage.
        for (int f = 0; f < 3; f++) begin
            add_slot(48, DW'($urandom));
            add_slot(48, DW'($urandom));
        end
        play("long", -1);

        // Reset mid right word, then a clean segment.
        add_slot(32, 16'hCAFE);
        add_slot(32, 16'hBEEF);
        add_slot(32, 16'h0F0F);
        add_slot(32, 16'hF0F0);
        play("prerst", 32 * 3 + 8);
        add_slot(32, 16'h1357);
        add_slot(32, 16'h2468);
        add_slot(32, 16'h9ABC);
        add_slot(32, 16'hDEF0);
        play("postrst", -1);

        // Mono corner words (also plain L/R checks when the mix is absent).
        add_slot(32, 16'h0000);
        add_slot(32, 16'h0000);
        add_slot(32, 16'h7FFF);
        add_slot(32, 16'h7FFF);
        add_slot(32, 16'h8000);
        add_slot(32, 16'h0001);
        add_slot(32, 16'hFFFF);
        add_slot(32, 16'h0000);
        play("mono", -1);

        // Random slot lengths (short, exact, long) and words.
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 14; s++) begin
                add_slot(int'($urandom_range(8, 40)), DW'($urandom));
            end
            play("rand", -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
